rr_priority_arbiter: RTL

Sequential arbiter that shares one resource among eight requesters, built around the combinational 8:3 priority-encoding datapath. It rotates priority after each grant so no requester starves, holds a grant while the owner keeps requesting, and preempts an owner that exceeds a hold limit while others wait. It sits between requester request lines and the shared resource's select/enable inputs.

---
 rtl/rr_priority_arbiter.sv | 92 +++++++++
 1 files changed

// File: rtl/rr_priority_arbiter.sv
// Round-robin arbiter for eight requesters with grant holding and hold-limit preemption.
// A descending, wrapping priority search feeds a two-state ARB/OWN controller with registered outputs.
module rr_priority_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_valid,
  output logic       IDLE
);

  typedef enum logic {ARB, OWN} state_t;

  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

  state_t     state;
  logic [2:0] ptr;
  logic [7:0] hold_cnt;

  logic [2:0] win_id;
  logic       win_found;
  logic [2:0] cand;
  logic       owner_req;
  logic       others_req;
  logic       drop_grant;

  // Search ptr, ptr-1, ..., wrapping below 0 back to 7; the first set request wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    win_id    = 3'd0;
    win_found = 1'b0;
    cand      = 3'd0;
    for (int i = 0; i < 8; i++) begin
      cand = ptr - 3'(i);
      if (!win_found && req[cand]) begin
        win_id    = cand;
        win_found = 1'b1;
      end
    end
  end

  assign owner_req  = req[gnt_id];
  assign others_req = |(req & ~gnt);
  assign drop_grant = !owner_req || ((hold_cnt == HOLD_MAX) && others_req);

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB;
      ptr       <= 3'd7;
      hold_cnt  <= 8'd0;
      gnt       <= 8'd0;
      gnt_id    <= 3'd0;
      gnt_valid <= 1'b0;
      IDLE      <= 1'b1;
    end else begin
      case (state)
        ARB: begin
          if (win_found) begin
            state     <= OWN;
            gnt       <= 8'd1 << win_id;
            gnt_id    <= win_id;
            gnt_valid <= 1'b1;
            IDLE      <= 1'b0;
            hold_cnt  <= 8'd1;
            // Moving ptr just past the winner gives it the lowest priority next time.
            ptr       <= win_id - 3'd1;
          end else begin
            IDLE      <= 1'b1;
          end
        end
        OWN: begin
          if (drop_grant) begin
            state     <= ARB;
            gnt       <= 8'd0;
            gnt_id    <= 3'd0;
            gnt_valid <= 1'b0;
            hold_cnt  <= 8'd0;
            IDLE      <= (req == 8'd0);
          end else if (hold_cnt != HOLD_MAX) begin
            hold_cnt  <= hold_cnt + 8'd1;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule
